// File: rtl/dcache_write_buffer.sv
// Posted line-write buffer between the D-cache memory port and slow memory; drains in FIFO order.
// Define WBUF_READ_FWD_EN to serve read hits from the buffer and let read misses bypass queued drains.
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_FWD  = 3'd4;

    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic [2:0]        state;

    logic              read_req;
    logic              write_req;
    logic              full;
    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic              drain_go;
    logic              start_rd;
    logic              start_fwd;
    logic              head_busy;
    logic              coalesce;
    logic              push;
    logic              pop;

    // Requests seen while c_ready is high belong to the transaction just completed.
    assign read_req  = c_read && !c_ready;
    assign write_req = c_write && !c_read && !c_ready;
    assign full      = (count == FULL_COUNT);

    // Youngest valid entry matching c_addr: later (younger) matches overwrite earlier ones.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((k < 32'(count)) && (buf_addr[idx] == c_addr)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

`ifdef WBUF_READ_FWD_EN
    assign start_fwd = (state == S_IDLE) && read_req && hit;
    assign start_rd  = (state == S_IDLE) && read_req && !hit;
    assign drain_go  = (state == S_IDLE) && !read_req && (count != '0);
`else
    assign start_fwd = 1'b0;
    assign start_rd  = (state == S_IDLE) && read_req && (count == '0);
    assign drain_go  = (state == S_IDLE) && (count != '0);
`endif

    // The head is busy both while draining and in the cycle its drain is launched,
    // since mem_wdata captures it on that edge.
    assign head_busy = (state == S_DR) || drain_go;
    assign coalesce  = write_req && !full && hit && !(head_busy && (hit_idx == rd_ptr));
    assign push      = write_req && !full && !coalesce;
    assign pop       = (state == S_DR) && mem_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= c_addr;
            buf_data[wr_ptr] <= c_wdata;
        end else if (coalesce) begin
            buf_data[hit_idx] <= c_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            c_rdata   <= '0;
            c_ready   <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            c_ready <= push || coalesce;
            case (state)
                S_IDLE: begin
                    if (start_fwd) begin
                        c_rdata <= buf_data[hit_idx];
                        c_ready <= 1'b1;
                        state   <= S_FWD;
                    end else if (start_rd) begin
                        mem_read <= 1'b1;
                        mem_addr <= c_addr;
                        state    <= S_RD;
                    end else if (drain_go) begin
                        mem_write <= 1'b1;
                        mem_addr  <= buf_addr[rd_ptr];
                        mem_wdata <= buf_data[rd_ptr];
                        state     <= S_DR;
                    end
                end
                S_DR: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        c_rdata  <= mem_rdata;
                        mem_read <= 1'b0;
                        c_ready  <= 1'b1;
                        state    <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                S_FWD:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
